alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle sequencer that sits in front of the shifter+ALU datapath and owns the architectural NZCV flag register. It accepts one operation command per valid/ready handshake and evaluates its 4-bit condition code against the registered flags. On a pass it drives the datapath controls for exactly one execute cycle, captures the result and, when S=1, the new flags. It returns the result with a valid/ready handshake, so the decode/issue logic never drives the combinational datapath directly.

## Interface
Parameters:
- none; datapath widths fixed: data 32, shift count 8, SHIFT_OP 3, ALU_OP 4, cond 4.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command (IDLE only)
- cmd_cond  in  4  condition code, ARM encoding
- cmd_alu_op  in  4  ALU operation, passed to datapath unchanged
- cmd_shift_op  in  3  shifter operation, passed unchanged
- cmd_shift_num  in  8  shift amount, passed unchanged
- cmd_a  in  32  ALU operand A
- cmd_b  in  32  shifter data (second operand before shift)
- cmd_s  in  1  update flags on execute
- dp_a  out  32  datapath operand A
- dp_shift_data  out  32  datapath shifter data
- dp_shift_num  out  8  datapath shift amount
- dp_shift_op  out  3  datapath SHIFT_OP
- dp_alu_op  out  4  datapath ALU_OP
- dp_s  out  1  datapath S; high only in EXEC with latched s=1
- dp_carry_in  out  1  registered C flag, fed to shifter/ALU carry input
- dp_f  in  32  datapath result (combinational)
- dp_nzcv  in  4  datapath flags {N,Z,C,V} (combinational)
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  32  captured result; 0 if condition failed
- res_executed  out  1  1 = condition passed and op executed
- flags  out  4  architectural NZCV register {N,Z,C,V}

## Operation
- States: IDLE, EXEC, RESP. Encoding is free; reset state is IDLE.
- IDLE: cmd_ready=1.
  - On cmd_valid&cmd_ready, latch all cmd_* fields into dp_* registers.
  - Evaluate the condition against the current flags.
  - Pass -> EXEC. Fail -> RESP with res_data=0 and res_executed=0; flags unchanged.
- Condition evaluation:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL always passes; 1111 NV never passes.
- EXEC (one cycle): dp_* hold latched values, dp_s = latched s.
  - At the cycle-ending edge, res_data <= dp_f and res_executed <= 1.
  - If latched s=1, flags <= dp_nzcv; otherwise flags are unchanged.
  - -> RESP.
- RESP: res_valid=1; res_data and res_executed held stable.
  - On res_ready -> IDLE.
  - cmd_ready=0 in RESP, including the cycle in which res_ready is sampled high.
- dp_carry_in always equals flags[1]. During EXEC it is the pre-update C.
- dp_a, dp_shift_data, dp_shift_num, dp_shift_op and dp_alu_op hold their last latched value outside EXEC. dp_s=0 outside EXEC.
- Flags change only at the end of an EXEC with s=1.

## Timing
- Reset (async, immediate):
  - state=IDLE; cmd_ready=1; res_valid=0; res_data=0; res_executed=0; flags=0000.
  - All dp_* = 0, so dp_carry_in=0.
- Reset asserted mid-operation (EXEC or RESP): the operation is dropped, no flag update occurs, and every output takes its reset value.
- Executed op: command accepted at edge k; EXEC during cycle k..k+1; res_valid high from edge k+1.
- Failed condition: accepted at edge k; res_valid high from edge k+1, skipping EXEC.
- res_valid stays high until the first edge with res_ready=1. It falls at that edge, and cmd_ready rises at that same edge.
- Maximum throughput: one command per 3 cycles executed, one per 2 cycles failed, with res_ready tied high.
- Command N+1 is evaluated against the flags written by command N, with no hazard window.
- cmd_* fields are ignored when cmd_ready=0.

## Test plan
- Reset mid-operation: assert rst during EXEC of an S=1 op, with the model returning nzcv=1111 -> flags=0000, res_valid=0, cmd_ready=1 immediately; no result is ever produced.
- Basic execute: flags=0000, cond=1110, s=1, model dp_f=0x0000_0005, dp_nzcv=0010 -> res_valid at accept+1 edge, res_data=0x5, res_executed=1, flags=0010.
- No flag update: s=0, dp_nzcv=1001 -> flags unchanged, res_data=dp_f; dp_s stays 0 every cycle.
- Condition fail: flags=0000, cond=0000 (EQ) -> no EXEC cycle, dp_s never high, res_executed=0, res_data=0, flags=0000.
- Condition sweep: for all 16 cond values × 16 flag values (flags preloaded via an S=1 op) -> res_executed matches the condition evaluation table exactly; 1111 always gives 0.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid, res_data and res_executed stable; cmd_ready=0 throughout; cmd_valid pulses ignored. Raise res_ready -> IDLE next edge, new command accepted.
- Flag chaining: op1 s=1 returns Z=1; op2 cond=0001 (NE) issued back-to-back -> op2 res_executed=0.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl_if
//  Description : Bundle of the command, datapath and result signals of the
//                ALU sequencer.
//                - slave  : view of the sequencer itself.
//                - master : view of the surrounding logic, which is the
//                  issue stage plus the combinational shifter/ALU datapath.
//  Signals     : cmd_*  command channel (valid/ready)
//                dp_*   datapath controls out, dp_f/dp_nzcv results in
//                res_*  result channel (valid/ready)
//                flags  architectural NZCV register
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_seq_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_cond;
    logic [3:0]  cmd_alu_op;
    logic [2:0]  cmd_shift_op;
    logic [7:0]  cmd_shift_num;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_s;

    logic [31:0] dp_a;
    logic [31:0] dp_shift_data;
    logic [7:0]  dp_shift_num;
    logic [2:0]  dp_shift_op;
    logic [3:0]  dp_alu_op;
    logic        dp_s;
    logic        dp_carry_in;
    logic [31:0] dp_f;
    logic [3:0]  dp_nzcv;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_executed;
    logic [3:0]  flags;

    modport slave (
        input  cmd_valid, cmd_cond, cmd_alu_op, cmd_shift_op, cmd_shift_num,
               cmd_a, cmd_b, cmd_s, dp_f, dp_nzcv, res_ready,
        output cmd_ready, dp_a, dp_shift_data, dp_shift_num, dp_shift_op,
               dp_alu_op, dp_s, dp_carry_in, res_valid, res_data,
               res_executed, flags
    );

    modport master (
        output cmd_valid, cmd_cond, cmd_alu_op, cmd_shift_op, cmd_shift_num,
               cmd_a, cmd_b, cmd_s, dp_f, dp_nzcv, res_ready,
        input  cmd_ready, dp_a, dp_shift_data, dp_shift_num, dp_shift_op,
               dp_alu_op, dp_s, dp_carry_in, res_valid, res_data,
               res_executed, flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Three-state sequencer (IDLE/EXEC/RESP) in front of the
//                shifter+ALU datapath. Accepts one command and checks its
//                ARM condition code against the NZCV register.
//                - pass : drives the datapath for one EXEC cycle, captures
//                  dp_f and, when S=1, dp_nzcv.
//                - fail : goes straight to RESP with a zero result.
//  Ports       : clk, rst (async, active high)
//                bus  alu_seq_ctrl_if.slave, carrying the command channel,
//                     the datapath controls/results, the result channel
//                     and the flags.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq_ctrl (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q,        state_d;
    logic [31:0] a_q,            a_d;
    logic [31:0] shift_data_q,   shift_data_d;
    logic [7:0]  shift_num_q,    shift_num_d;
    logic [2:0]  shift_op_q,     shift_op_d;
    logic [3:0]  alu_op_q,       alu_op_d;
    logic        s_q,            s_d;
    logic [3:0]  flags_q,        flags_d;
    logic [31:0] res_data_q,     res_data_d;
    logic        res_executed_q, res_executed_d;

    logic w_n, w_z, w_c, w_v;
    logic cond_pass;

    assign w_n = flags_q[3];
    assign w_z = flags_q[2];
    assign w_c = flags_q[1];
    assign w_v = flags_q[0];

    // Condition is checked against the registered flags. Those flags already
    // include any update from the previous command, so chained ops see no
    // hazard.
    always_comb begin
        cond_pass = 1'b0;
        case (bus.cmd_cond)
            4'b0000: cond_pass = w_z;
            4'b0001: cond_pass = ~w_z;
            4'b0010: cond_pass = w_c;
            4'b0011: cond_pass = ~w_c;
            4'b0100: cond_pass = w_n;
            4'b0101: cond_pass = ~w_n;
            4'b0110: cond_pass = w_v;
            4'b0111: cond_pass = ~w_v;
            4'b1000: cond_pass = w_c & ~w_z;
            4'b1001: cond_pass = ~w_c | w_z;
            4'b1010: cond_pass = (w_n == w_v);
            4'b1011: cond_pass = (w_n != w_v);
            4'b1100: cond_pass = ~w_z & (w_n == w_v);
            4'b1101: cond_pass = w_z | (w_n != w_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        shift_data_d   = shift_data_q;
        shift_num_d    = shift_num_q;
        shift_op_d     = shift_op_q;
        alu_op_d       = alu_op_q;
        s_d            = s_q;
        flags_d        = flags_q;
        res_data_d     = res_data_q;
        res_executed_d = res_executed_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    a_d          = bus.cmd_a;
                    shift_data_d = bus.cmd_b;
                    shift_num_d  = bus.cmd_shift_num;
                    shift_op_d   = bus.cmd_shift_op;
                    alu_op_d     = bus.cmd_alu_op;
                    s_d          = bus.cmd_s;
                    if (cond_pass) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d        = S_RESP;
                        res_data_d     = 32'd0;
                        res_executed_d = 1'b0;
                    end
                end
            end
            S_EXEC: begin
                res_data_d     = bus.dp_f;
                res_executed_d = 1'b1;
                if (s_q) begin
                    flags_d = bus.dp_nzcv;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            a_q            <= 32'd0;
            shift_data_q   <= 32'd0;
            shift_num_q    <= 8'd0;
            shift_op_q     <= 3'd0;
            alu_op_q       <= 4'd0;
            s_q            <= 1'b0;
            flags_q        <= 4'd0;
            res_data_q     <= 32'd0;
            res_executed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            shift_data_q   <= shift_data_d;
            shift_num_q    <= shift_num_d;
            shift_op_q     <= shift_op_d;
            alu_op_q       <= alu_op_d;
            s_q            <= s_d;
            flags_q        <= flags_d;
            res_data_q     <= res_data_d;
            res_executed_q <= res_executed_d;
        end
    end

    assign bus.cmd_ready     = (state_q == S_IDLE);
    assign bus.res_valid     = (state_q == S_RESP);
    assign bus.dp_a          = a_q;
    assign bus.dp_shift_data = shift_data_q;
    assign bus.dp_shift_num  = shift_num_q;
    assign bus.dp_shift_op   = shift_op_q;
    assign bus.dp_alu_op     = alu_op_q;
    // S reaches the datapath only in the single execute cycle.
    assign bus.dp_s          = (state_q == S_EXEC) & s_q;
    // Carry-in is the registered C flag; in EXEC this is the pre-update value.
    assign bus.dp_carry_in   = flags_q[1];
    assign bus.res_data      = res_data_q;
    assign bus.res_executed  = res_executed_q;
    assign bus.flags         = flags_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_ctrl
//  Description : Testbench for alu_seq_ctrl. The bench plays both the issue
//                stage and the datapath. Expected results go onto a queue
//                when a command is driven and are popped when res_valid
//                appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_ctrl_if bus ();
    alu_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] data;
        logic        exec;
        logic [3:0]  flags;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  mflags = 4'd0;

    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Offers one command, pushes its expected result, and checks the cycle
    // right after acceptance.
    task automatic issue(input logic [3:0] cond, input logic s, input logic [31:0] f,
                         input logic [3:0] nzcv, input logic [31:0] a, output logic passed);
        int n;
        exp_t e;
        logic [3:0] pre;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL issue_wait: cmd_ready=%b required 1", bus.cmd_ready);
        end
        bus.cmd_valid     = 1'b1;
        bus.cmd_cond      = cond;
        bus.cmd_s         = s;
        bus.cmd_a         = a;
        bus.cmd_b         = a ^ 32'hA5A5_5A5A;
        bus.cmd_alu_op    = a[3:0];
        bus.cmd_shift_op  = a[6:4];
        bus.cmd_shift_num = a[15:8];
        bus.dp_f          = f;
        bus.dp_nzcv       = nzcv;
        pre    = mflags;
        passed = model_cond(cond, mflags);
        e.data = passed ? f : 32'd0;
        e.exec = passed;
        if (passed && s) mflags = nzcv;
        e.flags = mflags;
        sb.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = $urandom();
        bus.cmd_b     = $urandom();
        if (passed) begin
            checks++;
            if (bus.res_valid !== 1'b0 || bus.dp_s !== s) begin
                errors++; $display("FAIL exec_cycle: res_valid=%b dp_s=%b required 0 %b", bus.res_valid, bus.dp_s, s);
            end
            checks++;
            if (bus.dp_carry_in !== pre[1] || bus.flags !== pre) begin
                errors++; $display("FAIL exec_flags: carry_in=%b flags=%b required %b %b", bus.dp_carry_in, bus.flags, pre[1], pre);
            end
            checks++;
            if (bus.dp_a !== a || bus.dp_shift_data !== (a ^ 32'hA5A5_5A5A) || bus.dp_alu_op !== a[3:0]
                || bus.dp_shift_op !== a[6:4] || bus.dp_shift_num !== a[15:8]) begin
                errors++; $display("FAIL exec_dp: dp_a=%h dp_sd=%h op=%h sop=%h sn=%h required a=%h", bus.dp_a,
                                   bus.dp_shift_data, bus.dp_alu_op, bus.dp_shift_op, bus.dp_shift_num, a);
            end
        end else begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.dp_s !== 1'b0) begin
                errors++; $display("FAIL fail_skip: res_valid=%b dp_s=%b required 1 0", bus.res_valid, bus.dp_s);
            end
        end
    endtask

    // Waits for a result, compares it with the oldest expectation, then
    // takes it with a single res_ready pulse.
    task automatic collect(input string tag);
        int n;
        exp_t e;
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (bus.res_valid !== 1'b1) begin
            errors++; $display("FAIL %s_timeout: res_valid=%b required 1", tag, bus.res_valid);
        end
        if (sb.size() == 0) begin
            errors++; $display("FAIL %s_sb: queue size=0 required >0", tag);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.res_data !== e.data || bus.res_executed !== e.exec) begin
            errors++; $display("FAIL %s_result: data=%h exec=%b required %h %b", tag, bus.res_data, bus.res_executed, e.data, e.exec);
        end
        checks++;
        if (bus.flags !== e.flags) begin
            errors++; $display("FAIL %s_flags: flags=%b required %b", tag, bus.flags, e.flags);
        end
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.dp_s !== 1'b0) begin
            errors++; $display("FAIL %s_resp: cmd_ready=%b dp_s=%b required 0 0", tag, bus.cmd_ready, bus.dp_s);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s_release: res_valid=%b cmd_ready=%b required 0 1", tag, bus.res_valid, bus.cmd_ready);
        end
    endtask

    task automatic run_op(input logic [3:0] cond, input logic s, input logic [31:0] f,
                          input logic [3:0] nzcv, input string tag);
        logic p;
        issue(cond, s, f, nzcv, $urandom(), p);
        collect(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_cond = 4'd0; bus.cmd_s = 1'b0;
        bus.cmd_a = 32'd0; bus.cmd_b = 32'd0; bus.cmd_alu_op = 4'd0;
        bus.cmd_shift_op = 3'd0; bus.cmd_shift_num = 8'd0;
        bus.dp_f = 32'd0; bus.dp_nzcv = 4'd0; bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_data !== 32'd0
            || bus.res_executed !== 1'b0 || bus.flags !== 4'd0) begin
            errors++; $display("FAIL reset_out: rdy=%b vld=%b data=%h exec=%b flags=%b required 1 0 0 0 0",
                               bus.cmd_ready, bus.res_valid, bus.res_data, bus.res_executed, bus.flags);
        end
        checks++;
        if (bus.dp_a !== 32'd0 || bus.dp_shift_data !== 32'd0 || bus.dp_s !== 1'b0 || bus.dp_carry_in !== 1'b0) begin
            errors++; $display("FAIL reset_dp: dp_a=%h dp_sd=%h dp_s=%b cin=%b required 0", bus.dp_a, bus.dp_shift_data, bus.dp_s, bus.dp_carry_in);
        end
        rst = 1'b0;
        mflags = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(4'hE, 1'b1, 32'h0000_0005, 4'b0010, "basic");
    endtask

    task automatic test_no_flag_update();
        run_op(4'hE, 1'b0, 32'hDEAD_BEEF, 4'b1001, "noflag");
    endtask

    task automatic test_cond_fail();
        run_op(4'hE, 1'b1, 32'h0000_0001, 4'b0000, "preload0");
        run_op(4'h0, 1'b1, 32'h1234_0000, 4'b1111, "condfail");
    endtask

    task automatic test_sweep();
        for (int fl = 0; fl < 16; fl++) begin
            run_op(4'hE, 1'b1, 32'h0, 4'(fl), "sweep_pre");
            for (int c = 0; c < 16; c++) begin
                run_op(4'(c), 1'b0, 32'h100 + 32'(fl * 16 + c), 4'b0000, "sweep");
            end
        end
    endtask

    task automatic test_backpressure();
        logic p;
        logic [31:0] a;
        a = 32'h0BAD_F00D;
        issue(4'hE, 1'b1, 32'h1234_5678, 4'b1000, a, p);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h1234_5678 || bus.res_executed !== 1'b1
                || bus.cmd_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold: vld=%b data=%h exec=%b rdy=%b required 1 12345678 1 0",
                                   bus.res_valid, bus.res_data, bus.res_executed, bus.cmd_ready);
            end
            bus.cmd_valid = (i % 2 == 0);
            bus.cmd_cond  = 4'hE;
            bus.cmd_a     = $urandom();
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.dp_a !== a) begin
            errors++; $display("FAIL bp_ignore: dp_a=%h required %h", bus.dp_a, a);
        end
        collect("bp");
        run_op(4'h4, 1'b0, 32'h0000_00AA, 4'b0000, "bp_next");
    endtask

    task automatic test_chain();
        run_op(4'hE, 1'b1, 32'h0, 4'b0100, "chain1");
        run_op(4'h1, 1'b1, 32'h77, 4'b0000, "chain2");
        checks++;
        if (bus.flags !== 4'b0100) begin
            errors++; $display("FAIL chain_flags: flags=%b required 0100", bus.flags);
        end
    endtask

    task automatic test_reset_mid();
        run_op(4'hE, 1'b1, 32'h0, 4'b1010, "rm_pre");
        bus.cmd_valid = 1'b1; bus.cmd_cond = 4'hE; bus.cmd_s = 1'b1;
        bus.cmd_a = 32'h5555_AAAA; bus.dp_f = 32'hFFFF_FFFF; bus.dp_nzcv = 4'b1111;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.dp_s !== 1'b1) begin
            errors++; $display("FAIL rm_exec: dp_s=%b required 1", bus.dp_s);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.flags !== 4'd0 || bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1
            || bus.dp_a !== 32'd0 || bus.dp_s !== 1'b0 || bus.dp_carry_in !== 1'b0) begin
            errors++; $display("FAIL rm_async: flags=%b vld=%b rdy=%b dp_a=%h dp_s=%b required 0 0 1 0 0",
                               bus.flags, bus.res_valid, bus.cmd_ready, bus.dp_a, bus.dp_s);
        end
        @(negedge clk);
        rst = 1'b0;
        mflags = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.res_valid !== 1'b0 || bus.flags !== 4'd0 || bus.cmd_ready !== 1'b1) begin
                errors++; $display("FAIL rm_after: vld=%b flags=%b rdy=%b required 0 0000 1", bus.res_valid, bus.flags, bus.cmd_ready);
            end
        end
        run_op(4'h0, 1'b0, 32'h9, 4'b0000, "rm_next");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_flag_update();
        test_cond_fail();
        test_sweep();
        test_backpressure();
        test_chain();
        test_reset_mid();
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: size=%0d required 0", sb.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time=%0t required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
